decoder_select_arbiter: RTL and testbench

//  Round-robin arbiter sharing one 2-of-4 active-low select decoder between four requesters.

---
 rtl/decoder_select_arbiter.sv | 127 ++++++++++++
 tb/tb_decoder_select_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/decoder_select_arbiter.sv
// Round-robin arbiter sharing a 2-of-4 active-low select decoder between four requesters.
// Optional ARB_LOCK_EN adds a lock input that suppresses the tenure timeout.
module decoder_select_arbiter #(
    parameter int unsigned HOLD_MAX = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
`ifdef ARB_LOCK_EN
    input  logic       lock,
`endif
    output logic       g_n,
    output logic       a,
    output logic       b,
    output logic [3:0] gnt,
    output logic       busy
);

    typedef enum logic [1:0] {StIdle, StGrant, StTurn} state_e;

    localparam bit TimeoutEn = (HOLD_MAX != 0);
    localparam logic [CNT_W-1:0] HoldLast = TimeoutEn ? CNT_W'(HOLD_MAX - 1) : '0;

    state_e           state_q, state_d;
    logic             g_n_q, g_n_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             pick_found;
    logic [1:0]       pick_idx;
    logic             hold_lock;
    logic             release_now;

`ifdef ARB_LOCK_EN
    assign hold_lock = lock;
`else
    assign hold_lock = 1'b0;
`endif

    // First requesting slot in search order ptr, ptr+1, ptr+2, ptr+3.
    always_comb begin
        logic [1:0] cand;
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        cand       = ptr_q;
        for (int i = 0; i < 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign release_now = !req[sel_q] ||
                         (TimeoutEn && (cnt_q == HoldLast) && !hold_lock);

    always_comb begin
        state_d = state_q;
        g_n_d   = g_n_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle, StTurn: begin
                if (pick_found) begin
                    state_d = StGrant;
                    g_n_d   = 1'b0;
                    sel_d   = pick_idx;
                    gnt_d   = 4'b0001 << pick_idx;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                    g_n_d   = 1'b1;
                    gnt_d   = 4'b0000;
                    busy_d  = 1'b0;
                end
            end
            StGrant: begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                // {b,a} deliberately keep the last index through TURN/IDLE.
                if (release_now) begin
                    state_d = StTurn;
                    g_n_d   = 1'b1;
                    gnt_d   = 4'b0000;
                    busy_d  = 1'b0;
                    ptr_d   = sel_q + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            g_n_q   <= 1'b1;
            sel_q   <= 2'b00;
            gnt_q   <= 4'b0000;
            busy_q  <= 1'b0;
            ptr_q   <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            g_n_q   <= g_n_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign g_n  = g_n_q;
    assign a    = sel_q[0];
    assign b    = sel_q[1];
    assign gnt  = gnt_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_decoder_select_arbiter.sv
// Bench for decoder_select_arbiter: owner/tenure model checked every cycle plus directed scenarios.
module tb_decoder_select_arbiter;

    localparam int HOLD = 4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
`ifdef ARB_LOCK_EN
    logic       lock;
`endif
    logic       g_n, a, b, busy;
    logic [3:0] gnt;

    int n_checks = 0;
    int n_pass   = 0;

    decoder_select_arbiter #(.HOLD_MAX(HOLD), .CNT_W(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
`ifdef ARB_LOCK_EN
        .lock (lock),
`endif
        .g_n  (g_n),
        .a    (a),
        .b    (b),
        .gnt  (gnt),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: who owns the decoder, how long they have held it, and where the search starts.
    int  m_owner  = -1;
    int  m_last   = 0;
    int  m_ptr    = 0;
    int  m_tenure = 0;
    int  m_s;
    logic lock_now;

`ifdef ARB_LOCK_EN
    assign lock_now = lock;
`else
    assign lock_now = 1'b0;
`endif

    always @(posedge clk) begin
        if (rst) begin
            m_owner = -1; m_last = 0; m_ptr = 0; m_tenure = 0;
        end else if (m_owner >= 0) begin
            m_tenure++;
            if (!req[m_owner] || (HOLD > 0 && m_tenure == HOLD && !lock_now)) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                m_s = (m_ptr + i) % 4;
                if (m_owner < 0 && req[m_s]) begin
                    m_owner = m_s; m_last = m_s; m_tenure = 0;
                end
            end
        end
    end

    logic [3:0] prev_gnt = 4'b0000;

    always @(negedge clk) begin
        check("g_n", 32'(g_n), 32'(m_owner < 0));
        check("sel", 32'({b, a}), 32'(m_last));
        check("gnt", 32'(gnt), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
        check("busy", 32'(busy), 32'(m_owner >= 0));
        check("gnt_vs_sel", 32'(gnt), g_n ? 32'd0 : (32'd1 << {b, a}));
        if (prev_gnt != 4'b0000 && gnt != 4'b0000) check("bbm", 32'(gnt), 32'(prev_gnt));
        prev_gnt = gnt;
    end

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic restart();
        rst = 1'b1; req = 4'b0000;
        nxt();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 4'b1111;
`ifdef ARB_LOCK_EN
        lock = 1'b0;
`endif
        // Reset held with all requests active.
        for (int i = 0; i < 2; i++) begin
            nxt();
            check("s1_rst_g_n", 32'(g_n), 32'd1);
            check("s1_rst_gnt", 32'(gnt), 32'd0);
            check("s1_rst_sel", 32'({b, a}), 32'd0);
        end
        rst = 1'b0;
        nxt();
        check("s1_first_gnt", 32'(gnt), 32'b0001);
        check("s1_first_g_n", 32'(g_n), 32'd0);
        check("s1_first_sel", 32'({b, a}), 32'd0);

        // All requesting: 0,1,2,3,0 each 4 cycles then a one-cycle gap.
        for (int k = 0; k < 25; k++) begin
            if (k > 0) nxt();
            check("s3_rr", 32'(gnt), (k % 5 == 4) ? 32'd0 : (32'd1 << ((k / 5) % 4)));
        end

        // Single requester holding for three cycles.
        restart();
        req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            nxt();
            check("s2_gnt", 32'(gnt), 32'b0100);
            check("s2_sel", 32'({b, a}), 32'd2);
            check("s2_g_n", 32'(g_n), 32'd0);
        end
        req = 4'b0000;
        nxt();
        check("s2_turn_g_n", 32'(g_n), 32'd1);
        check("s2_turn_gnt", 32'(gnt), 32'd0);
        check("s2_turn_sel", 32'({b, a}), 32'd2);
        nxt();
        check("s2_idle_busy", 32'(busy), 32'd0);

        // Slot 1 releases, ptr=2, then slots 3 and 1 request.
        restart();
        req = 4'b0010;
        nxt();
        check("s4_gnt1", 32'(gnt), 32'b0010);
        req = 4'b0000;
        nxt();
        check("s4_gap", 32'(g_n), 32'd1);
        req = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            nxt();
            check("s4_gnt3", 32'(gnt), 32'b1000);
            check("s4_sel3", 32'({b, a}), 32'd3);
        end
        nxt();
        check("s4_gap2", 32'(gnt), 32'd0);
        nxt();
        check("s4_gnt1b", 32'(gnt), 32'b0010);
        check("s4_sel1", 32'({b, a}), 32'd1);

        // Reset in the middle of a slot-2 grant.
        restart();
        req = 4'b0100;
        nxt();
        check("s5_gnt2", 32'(gnt), 32'b0100);
        rst = 1'b1; req = 4'b1111;
        nxt();
        check("s5_rst_g_n", 32'(g_n), 32'd1);
        check("s5_rst_gnt", 32'(gnt), 32'd0);
        rst = 1'b0;
        nxt();
        check("s5_ptr_reset", 32'(gnt), 32'b0001);

        // Two requesters: timeout hands over, lock keeps slot 0.
        restart();
        req = 4'b0011;
`ifdef ARB_LOCK_EN
        lock = 1'b1;
        for (int i = 0; i < 10; i++) begin
            nxt();
            check("s6_locked", 32'(gnt), 32'b0001);
        end
        req = 4'b0010;
`else
        for (int i = 0; i < HOLD; i++) begin
            nxt();
            check("s6_tenure", 32'(gnt), 32'b0001);
        end
`endif
        nxt();
        check("s6_gap", 32'(gnt), 32'd0);
        nxt();
        check("s6_next", 32'(gnt), 32'b0010);
        req = 4'b0000;
`ifdef ARB_LOCK_EN
        lock = 1'b0;
`endif
        nxt();
        nxt();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
